// File: rtl/tc_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among N thermocouple requesters.
// Sequences grant, enable, busy tracking, data capture and done, with a watchdog abort.
module tc_spi_arbiter #(
    parameter int N       = 4,
    parameter int SELW    = 2,
    parameter int TIMEOUT = 4000,
    parameter int TBITS   = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            spi_not_busy,
    input  logic [31:0]     spi_rx_data,
    output logic            spi_ena,
    output logic [SELW-1:0] spi_cs_sel,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [31:0]     rx_data,
    output logic            timeout_err,
    output logic [SELW-1:0] err_chan
);

    // state   | meaning
    // IDLE    | arbitrate among pending requests
    // ARM     | spi_ena held high, waiting for the master to go busy
    // XFER    | master busy, waiting for it to return idle
    // RELEASE | done pulse (or abort) cycle, no arbitration
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [TBITS-1:0]  wd_q, wd_d;
    logic              spi_ena_q, spi_ena_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      done_q, done_d;
    logic [31:0]       rx_data_q, rx_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic [SELW-1:0]   err_chan_q, err_chan_d;

    logic              found;
    logic [SELW-1:0]   win;
    int                idx;
    logic [SELW-1:0]   next_ptr;
    logic              wd_last;
    logic [N-1:0]      win_onehot;

    // Scan starting at ptr, wrapping at N-1; the first pending request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = SELW'(idx);
            end
        end
    end

    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;
    assign next_ptr   = (sel_q == SELW'(N-1)) ? '0 : sel_q + 1'b1;
    assign wd_last    = (wd_q == TBITS'(TIMEOUT-1));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        wd_d          = wd_q;
        spi_ena_d     = spi_ena_q;
        sel_d         = sel_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        rx_data_d     = rx_data_q;
        timeout_err_d = timeout_err_q;
        err_chan_d    = err_chan_q;

        case (state_q)
            IDLE: begin
                gnt_d     = '0;
                spi_ena_d = 1'b0;
                if (found) begin
                    gnt_d     = win_onehot;
                    sel_d     = win;
                    spi_ena_d = 1'b1;
                    wd_d      = '0;
                    state_d   = ARM;
                end
            end
            ARM, XFER: begin
                wd_d = wd_q + 1'b1;
                if (state_q == ARM && !spi_not_busy) begin
                    spi_ena_d = 1'b0;
                    state_d   = XFER;
                end
                // Completion takes priority over a watchdog expiry on the same edge.
                if (state_q == XFER && spi_not_busy) begin
                    rx_data_d = spi_rx_data;
                    done_d    = gnt_q;
                    gnt_d     = '0;
                    ptr_d     = next_ptr;
                    state_d   = RELEASE;
                end else if (wd_last) begin
                    spi_ena_d     = 1'b0;
                    gnt_d         = '0;
                    timeout_err_d = 1'b1;
                    err_chan_d    = sel_q;
                    ptr_d         = next_ptr;
                    state_d       = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            wd_q          <= '0;
            spi_ena_q     <= 1'b0;
            sel_q         <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            rx_data_q     <= '0;
            timeout_err_q <= 1'b0;
            err_chan_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wd_q          <= wd_d;
            spi_ena_q     <= spi_ena_d;
            sel_q         <= sel_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rx_data_q     <= rx_data_d;
            timeout_err_q <= timeout_err_d;
            err_chan_q    <= err_chan_d;
        end
    end

    assign spi_ena     = spi_ena_q;
    assign spi_cs_sel  = sel_q;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rx_data     = rx_data_q;
    assign timeout_err = timeout_err_q;
    assign err_chan    = err_chan_q;

endmodule

// File: tb/tb_tc_spi_arbiter.sv
// Scoreboard bench for tc_spi_arbiter: expected grants and done pulses are queued by the
// stimulus and popped by a monitor; a small SPI master model answers each enable.
module tb_tc_spi_arbiter;
    localparam int N = 4;
    localparam int SELW = 2;
    localparam int TIMEOUT = 16;
    localparam int TBITS = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic            spi_not_busy = 1'b1;
    logic [31:0]     spi_rx_data = '0;
    logic            spi_ena;
    logic [SELW-1:0] spi_cs_sel;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     rx_data;
    logic            timeout_err;
    logic [SELW-1:0] err_chan;

    tc_spi_arbiter #(.N(N), .SELW(SELW), .TIMEOUT(TIMEOUT), .TBITS(TBITS)) dut (
        .clk(clk), .rst(rst), .req(req), .spi_not_busy(spi_not_busy),
        .spi_rx_data(spi_rx_data), .spi_ena(spi_ena), .spi_cs_sel(spi_cs_sel),
        .gnt(gnt), .done(done), .rx_data(rx_data), .timeout_err(timeout_err),
        .err_chan(err_chan)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] data;
        int          cyc;
    } done_t;

    int    exp_gnt_q[$];
    done_t exp_done_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    m_busy = 5;
    logic [31:0] m_data = 32'h0;
    logic [N-1:0] gnt_prev = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] data, input int at);
        done_t d;
        d.ch = ch; d.data = data; d.cyc = at;
        exp_gnt_q.push_back(ch);
        exp_done_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_gnt_q.size() != 0 || exp_done_q.size() != 0 || req != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n >= 300), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // SPI master model: goes busy one cycle after enable, busy for m_busy cycles.
    initial forever begin
        int          b;
        logic [31:0] d;
        @(posedge clk);
        #1;
        if (spi_ena && m_busy > 0 && !rst) begin
            b = m_busy;
            d = m_data + 32'(spi_cs_sel);
            @(posedge clk);
            #1;
            spi_not_busy = 1'b0;
            repeat (b) @(posedge clk);
            #1;
            spi_rx_data  = d;
            spi_not_busy = 1'b1;
        end
    end

    // Requesters drop their request in their done cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) req = req & ~done;
    end

    // Monitor: compare each new grant and each done pulse against the scoreboard.
    initial forever begin
        int    e;
        done_t d;
        @(negedge clk);
        if (!rst) begin
            if (gnt != 0 && gnt_prev == 0) begin
                if (exp_gnt_q.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    e = exp_gnt_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(1) << e);
                    chk("spi_cs_sel", 32'(spi_cs_sel), 32'(e));
                    chk("spi_ena_at_gnt", 32'(spi_ena), 32'd1);
                end
            end
            if (done != 0) begin
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done", 32'(done), 32'(1) << d.ch);
                    chk("rx_data", rx_data, d.data);
                    if (d.cyc >= 0) chk("done_latency", 32'(cyc), 32'(d.cyc));
                end
            end
        end
        gnt_prev = gnt;
    end

    initial begin
        int n;
        int t0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_spi_ena", 32'(spi_ena), 32'd0);
        chk("rst_cs_sel", 32'(spi_cs_sel), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_err_chan", 32'(err_chan), 32'd0);

        // Single request, busy 5: done = B+3 cycles after the request is sampled
        m_busy = 5;
        m_data = 32'hA5A5_1234;
        t0 = cyc;
        push(0, 32'hA5A5_1234, t0 + 5 + 3);
        req = 4'b0001;
        drain("drain_single");
        chk("single_timeout_err", 32'(timeout_err), 32'd0);

        // All requesters from reset: 0,1,2,3 then channel 0 again
        do_reset();
        m_busy = 3;
        m_data = 32'hC0DE_0000;
        push(0, 32'hC0DE_0000, -1);
        push(1, 32'hC0DE_0001, -1);
        push(2, 32'hC0DE_0002, -1);
        push(3, 32'hC0DE_0003, -1);
        push(0, 32'hC0DE_0000, -1);
        req = 4'b1111;
        n = 0;
        while (!done[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rr_first_done_seen", 32'(n >= 100), 32'd0);
        @(negedge clk);
        req[0] = 1'b1;
        drain("drain_rr");

        // ptr = 1 now; one transfer on channel 1 moves it to 2
        m_data = 32'h1111_0000;
        push(1, 32'h1111_0001, -1);
        req = 4'b0010;
        drain("drain_ptr2");
        // req = 1010 with ptr = 2: channel 3 first, then 1, leaving ptr = 2
        push(3, 32'h1111_0003, -1);
        push(1, 32'h1111_0001, -1);
        req = 4'b1010;
        drain("drain_1010");
        // ptr = 2 shows up as channel 2 winning over channel 0
        push(2, 32'h1111_0002, -1);
        push(0, 32'h1111_0000, -1);
        req = 4'b0101;
        drain("drain_0101");

        // Watchdog abort on channel 1 with the master stuck idle, then a normal retry
        m_busy = 0;
        m_data = 32'h7777_0000;
        exp_gnt_q.push_back(1);
        push(1, 32'h7777_0001, -1);
        req = 4'b0010;
        n = 0;
        while (!spi_ena && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (spi_ena && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("abort_ena_cycles", 32'(n), 32'(TIMEOUT));
        chk("abort_timeout_err", 32'(timeout_err), 32'd1);
        chk("abort_err_chan", 32'(err_chan), 32'd1);
        chk("abort_gnt", 32'(gnt), 32'd0);
        m_busy = 4;
        drain("drain_retry");
        chk("retry_timeout_err_sticky", 32'(timeout_err), 32'd1);

        // Completion exactly on watchdog count TIMEOUT-1 wins over the abort
        do_reset();
        m_busy = TIMEOUT - 2;
        m_data = 32'h5A5A_0000;
        t0 = cyc;
        push(0, 32'h5A5A_0000, t0 + (TIMEOUT - 2) + 3);
        req = 4'b0001;
        drain("drain_edge_complete");
        chk("edge_timeout_err", 32'(timeout_err), 32'd0);

        // Reset during XFER on channel 2 (ptr = 1 beforehand)
        m_busy = 10;
        m_data = 32'h3C3C_0000;
        exp_gnt_q.push_back(2);
        req = 4'b0100;
        n = 0;
        while (!spi_ena && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (spi_ena && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("xrst_spi_ena", 32'(spi_ena), 32'd0);
        chk("xrst_gnt", 32'(gnt), 32'd0);
        chk("xrst_done", 32'(done), 32'd0);
        chk("xrst_cs_sel", 32'(spi_cs_sel), 32'd0);
        chk("xrst_rx_data", rx_data, 32'd0);
        rst = 1'b0;
        n = 0;
        while (!spi_not_busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("xrst_master_idle", 32'(n >= 30), 32'd0);
        repeat (2) @(negedge clk);
        chk("xrst_no_done", 32'(done), 32'd0);
        // ptr back at 0: channel 0 beats channel 3
        m_busy = 2;
        push(0, 32'h3C3C_0000, -1);
        push(3, 32'h3C3C_0003, -1);
        req = 4'b1001;
        drain("drain_after_rst");

        chk("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/tc_spi_arbiter.md
# tc_spi_arbiter

Round-robin arbiter that shares one SPI master (shared `spi_ena` / `spi_not_busy` / `spi_rx_data`) among N thermocouple-channel requesters. It sequences each transfer: grant, enable pulse, busy tracking, data capture and done pulse. A watchdog aborts hung transfers. The block sits between the per-channel thermocouple readers and the single SPI master; `spi_cs_sel` drives the chip-select mux.

## Interface
- N, 4: number of requesters, 2..16.
- SELW, 2: width of `spi_cs_sel`; 2^SELW >= N.
- TIMEOUT, 4000: max cycles from grant to transfer completion.
- TBITS, 12: watchdog counter width; 2^TBITS > TIMEOUT.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  level request per channel. Held high until that channel's `done` pulse (or retried after abort).
- spi_not_busy  in  1  1 = SPI master idle, 0 = transferring.
- spi_rx_data  in  32  SPI receive word; valid when `spi_not_busy` returns to 1.
- spi_ena  out  1  start request to SPI master.
- spi_cs_sel  out  SELW  index of the granted channel.
- gnt  out  N  one-hot grant; all-zero when idle.
- done  out  N  one-cycle one-hot pulse; `rx_data` is valid in the same cycle.
- rx_data  out  32  captured receive word.
- timeout_err  out  1  sticky abort flag; cleared only by `rst`.
- err_chan  out  SELW  channel of the most recent abort.

## Operation
- All outputs are registered.
- Reset values: `spi_ena` = 0, `spi_cs_sel` = 0, `gnt` = 0, `done` = 0, `rx_data` = 0, `timeout_err` = 0, `err_chan` = 0. Internal state: FSM = IDLE, `ptr` = 0, watchdog count = 0.
- Reset mid-transfer: behaviour is identical to the above. `spi_ena` drops on the reset edge and no `done` is issued.
- FSM has four states:
  - **IDLE (0)**: if `req` != 0, winner w = first set bit scanning ptr, ptr+1, …, wrapping at N-1 → 0. Then `gnt` <= onehot(w), `spi_cs_sel` <= w, `spi_ena` <= 1, watchdog <= 0, go to ARM. With no request, stay in IDLE with all outputs low.
  - **ARM (1)**: hold `spi_ena` = 1. When `spi_not_busy` == 0 is sampled, `spi_ena` <= 0 and go to XFER.
  - **XFER (2)**: when `spi_not_busy` == 1 is sampled, `rx_data` <= `spi_rx_data`, `done` <= `gnt`, `gnt` <= 0, `ptr` <= (w+1) mod N, go to RELEASE.
  - **RELEASE (3)**: `done` is high for this cycle only. No arbitration happens in this state. Next state is IDLE.
- Watchdog:
  - Increments every cycle in ARM and XFER.
  - When the count equals TIMEOUT-1 and no completion occurs on that edge, the transfer aborts: `spi_ena` <= 0, `gnt` <= 0, `timeout_err` <= 1, `err_chan` <= w, `ptr` <= (w+1) mod N, go to RELEASE with `done` = 0.
  - An aborted requester keeps `req` high and is retried in round-robin order.
- Completion and timeout on the same edge: completion wins; no error is recorded.
- Requesters must drop `req` in their `done` cycle, so the following IDLE cycle sees the updated `req`.
- `req` changes during ARM, XFER or RELEASE are ignored until the next IDLE cycle.
- Values of `req` bits at index >= N are not applicable; `ptr` wraps at N-1 → 0.

## Timing
- Request sampled in IDLE at edge k: `gnt`, `spi_cs_sel` and `spi_ena` are all high in cycle k+1.
- `spi_ena` falls one cycle after the first sampled `spi_not_busy` = 0.
- Completion sampled at edge m: `done` and `rx_data` are valid in cycle m+1; IDLE is reached in cycle m+2.
- Minimum transaction, with the master going busy 1 cycle after enable and busy for B cycles: request to `done` = B+3 cycles.
- Back-to-back: the next grant appears 2 cycles after `done`, since RELEASE and IDLE each take one cycle.
- Abort: with grant at cycle g, RELEASE occurs at cycle g+TIMEOUT.

## Test plan
- Single request, `req` = 0001, SPI busy 5 cycles, `spi_rx_data` = 0xA5A5_1234 → `gnt` = 0001, `spi_cs_sel` = 0, one `done` = 0001 pulse with `rx_data` = 0xA5A5_1234, `timeout_err` = 0.
- All requesters held, `req` = 1111 after reset → grants in order 0, 1, 2, 3, 0; never two `gnt` bits high at once.
- `req` = 1010 with `ptr` = 2 → channel 3 granted first, then 1; ptr ends at 2.
- TIMEOUT = 16, `spi_not_busy` stuck at 1 → `spi_ena` high 16 cycles, then drops; `timeout_err` = 1, `err_chan` = granted index, no `done`; the next request is then serviced normally.
- Completion exactly on cycle TIMEOUT-1 → `done` pulses, `timeout_err` stays 0.
- `rst` asserted during XFER → next cycle all outputs zero, no `done`; the next `req` = 0001 is granted from `ptr` = 0.
